// File: rtl/pe_mac_scheduler.sv
// pe_mac_scheduler: drives a weight-stationary MAC array channel by channel, accumulates
// per-position partial sums and hands finished results out through a small FIFO.
module pe_mac_scheduler #(
    parameter int BIT_WIDTH   = 8,
    parameter int ACC_WIDTH   = 18,
    parameter int TAPS        = 9,
    parameter int OUT_WIDTH   = 24,
    parameter int MAX_POS     = 16,
    parameter int MAX_CH      = 8,
    parameter int OFIFO_DEPTH = 4,
    localparam int PW = $clog2(MAX_POS + 1),
    localparam int CW = $clog2(MAX_CH + 1),
    localparam int IW = $clog2(MAX_POS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [PW-1:0]             cfg_num_pos,
    input  logic [CW-1:0]             cfg_num_ch,
    output logic                      busy,
    output logic                      done,
    input  logic                      wt_valid,
    output logic                      wt_ready,
    input  logic [TAPS*BIT_WIDTH-1:0] wt_data,
    input  logic                      win_valid,
    output logic                      win_ready,
    input  logic [TAPS*BIT_WIDTH-1:0] win_data,
    output logic                      mac_control,
    output logic [TAPS*BIT_WIDTH-1:0] mac_wt,
    output logic [TAPS*BIT_WIDTH-1:0] mac_data,
    input  logic [TAPS*ACC_WIDTH-1:0] mac_prod,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic [IW-1:0]             out_pos
);
    localparam int AW = $clog2(OFIFO_DEPTH);
    localparam int NW = $clog2(OFIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, FINISH} state_t;
    state_t state, state_nx;

    logic [PW-1:0]        num_pos, pos;
    logic [CW-1:0]        num_ch, ch;
    logic                 s1_v, s1_first, s1_last, s2_v, s2_first, s2_last;
    logic [IW-1:0]        s1_pos, s2_pos;
    logic [OUT_WIDTH-1:0] sum, s2_sum, result;
    logic [OUT_WIDTH-1:0] psum [MAX_POS];
    logic [OUT_WIDTH-1:0] fifo_data [OFIFO_DEPTH];
    logic [IW-1:0]        fifo_pos [OFIFO_DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [NW-1:0]        count;
    logic [NW:0]          occ;
    logic                 last_ch, cfg_ok, win_hs, push, pop, pipe_empty;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(OFIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mac_wt     = wt_data;
    assign mac_data   = win_data;
    assign busy       = state != IDLE;
    assign out_valid  = count != '0;
    assign out_data   = fifo_data[rd_ptr];
    assign out_pos    = fifo_pos[rd_ptr];
    assign last_ch    = ch == num_ch - 1'b1;
    assign cfg_ok     = cfg_num_pos != '0 && cfg_num_ch != '0;
    assign win_hs     = win_valid && win_ready;
    assign push       = s2_v && s2_last;
    assign pop        = out_valid && out_ready;
    assign pipe_empty = !s1_v && !s2_v;
    // FIFO slots already promised to results still travelling through the pipeline
    assign occ        = (NW+1)'(count) + (NW+1)'(s1_v) + (NW+1)'(s2_v);
    assign result     = s2_first ? s2_sum : psum[s2_pos] + s2_sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) sum = sum + OUT_WIDTH'(mac_prod[i*ACC_WIDTH +: ACC_WIDTH]);
    end

    always_comb begin
        state_nx    = state;
        wt_ready    = 1'b0;
        win_ready   = 1'b0;
        mac_control = 1'b0;
        case (state)
            IDLE:    if (start && cfg_ok) state_nx = LOAD_W;
            LOAD_W: begin
                wt_ready    = 1'b1;
                mac_control = wt_valid;
                if (wt_valid) state_nx = STREAM;
            end
            STREAM: begin
                win_ready = pos < num_pos && (!last_ch || occ < (NW+1)'(OFIFO_DEPTH));
                if (win_valid && win_ready && pos + 1'b1 == num_pos) state_nx = DRAIN;
            end
            DRAIN:   if (pipe_empty) state_nx = last_ch ? FINISH : LOAD_W;
            FINISH:  if (count == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            done    <= 1'b0;
            num_pos <= '0;
            num_ch  <= '0;
            pos     <= '0;
            ch      <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state <= state_nx;
            done  <= (state == IDLE && start && !cfg_ok) || (state == FINISH && count == '0);
            if (state == IDLE && start && cfg_ok) begin
                num_pos <= cfg_num_pos;
                num_ch  <= cfg_num_ch;
                pos     <= '0;
                ch      <= '0;
            end
            if (state == DRAIN && pipe_empty && !last_ch) begin
                ch  <= ch + 1'b1;
                pos <= '0;
            end
            if (win_hs) pos <= pos + 1'b1;
            s1_v <= win_hs;
            s2_v <= s1_v;
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + NW'(push) - NW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        s1_pos   <= pos[IW-1:0];
        s1_first <= ch == '0;
        s1_last  <= last_ch;
        s2_pos   <= s1_pos;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_sum   <= sum;
        if (s2_v && !s2_last) psum[s2_pos] <= result;
        if (push) begin
            fifo_data[wr_ptr] <= result;
            fifo_pos[wr_ptr]  <= s2_pos;
        end
    end
endmodule

// File: tb/tb_pe_mac_scheduler.sv
// tb_pe_mac_scheduler: table vectors, corner sequences and random jobs against a
// convolution reference computed directly from the stored weights and windows.
module tb_pe_mac_scheduler;
    localparam int TAPS = 9;
    localparam int BW   = 8;
    localparam int AW   = 18;

    logic             clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [4:0]       cfg_num_pos = '0;
    logic [3:0]       cfg_num_ch = '0;
    logic             busy, done, wt_valid = 1'b0, wt_ready, win_valid = 1'b0, win_ready;
    logic [TAPS*BW-1:0] wt_data = '0, win_data = '0, mac_wt, mac_data;
    logic             mac_control;
    logic [TAPS*AW-1:0] mac_prod = '0;
    logic             out_valid, out_ready = 1'b0;
    logic [23:0]      out_data;
    logic [3:0]       out_pos;

    int n_cmp = 0, n_err = 0;

    logic [7:0]  wts [8][TAPS];
    logic [7:0]  wins [8][16][TAPS];
    logic [23:0] exp_v [16];
    int          hs_cyc [16];
    logic [7:0]  aw_reg [TAPS];

    typedef struct {int nch; int npos; int wa; int wb; int da; int db; int exp0; int exp1;} vec_t;
    vec_t vecs [4];

    pe_mac_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .cfg_num_pos(cfg_num_pos), .cfg_num_ch(cfg_num_ch),
        .busy(busy), .done(done), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .mac_control(mac_control), .mac_wt(mac_wt), .mac_data(mac_data), .mac_prod(mac_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pos(out_pos)
    );

    always #5 clk = ~clk;

    // Weight-stationary multiplier array
    always @(posedge clk)
        for (int t = 0; t < TAPS; t++)
            if (mac_control) aw_reg[t] <= mac_wt[t*BW +: BW];
            else mac_prod[t*AW +: AW] <= 18'(mac_data[t*BW +: BW]) * 18'(aw_reg[t]);

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [TAPS*BW-1:0] pack_w(input int c);
        logic [TAPS*BW-1:0] r;
        for (int t = 0; t < TAPS; t++) r[t*BW +: BW] = wts[c < 8 ? c : 7][t];
        return r;
    endfunction

    function automatic logic [TAPS*BW-1:0] pack_d(input int c, input int p);
        logic [TAPS*BW-1:0] r;
        for (int t = 0; t < TAPS; t++) r[t*BW +: BW] = wins[c < 8 ? c : 7][p < 16 ? p : 15][t];
        return r;
    endfunction

    task automatic model(input int nch, input int npos);
        for (int p = 0; p < npos; p++) begin
            longint acc = 0;
            for (int c = 0; c < nch; c++)
                for (int t = 0; t < TAPS; t++) acc += longint'(wts[c][t]) * longint'(wins[c][p][t]);
            exp_v[p] = 24'(acc % 64'd16777216);
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < 8; c++)
            for (int t = 0; t < TAPS; t++) begin
                wts[c][t] = 8'($urandom_range(0, 255));
                for (int p = 0; p < 16; p++) wins[c][p][t] = 8'($urandom_range(0, 255));
            end
    endtask

    task automatic run_job(input int nch, input int npos, input int hold, input int rdy_pct,
                           input bit lat, input bit restart, input string tag, output int acc_hold);
        int wi = 0, ci = 0, pi = 0, got = 0, cyc = 0, rises = 0;
        bit finished = 0, prev_wr = 0;
        acc_hold = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_num_pos = 5'(npos);
        cfg_num_ch = 4'(nch);
        @(negedge clk);
        start = 1'b0;
        #1 check({tag, "_busy"}, busy, 1);
        while (!finished && cyc < 3000) begin
            wt_valid  = wi < nch;
            wt_data   = pack_w(wi);
            win_valid = ci < nch;
            win_data  = pack_d(ci, pi);
            out_ready = cyc >= hold && $urandom_range(1, 100) <= rdy_pct;
            start     = restart && cyc == 5;
            cfg_num_pos = restart ? 5'd3 : 5'(npos);
            cfg_num_ch  = restart ? 4'd1 : 4'(nch);
            #1;
            if (wt_ready && !prev_wr) rises++;
            prev_wr = wt_ready;
            if (wt_valid && wt_ready) wi++;
            if (win_valid && win_ready) begin
                if (ci == nch - 1) hs_cyc[pi] = cyc;
                if (cyc < hold) acc_hold++;
                pi++;
                if (pi == npos) begin
                    pi = 0;
                    ci++;
                end
            end
            if (out_valid && out_ready) begin
                check({tag, "_pos"}, out_pos, got);
                check({tag, "_data"}, out_data, got < 16 ? exp_v[got] : 0);
                if (lat) check({tag, "_latency"}, cyc - hs_cyc[got < 16 ? got : 15], 3);
                got++;
            end
            if (done) begin
                check({tag, "_count_at_done"}, got, npos);
                check({tag, "_busy_at_done"}, busy, 0);
                check({tag, "_wt_rises"}, rises, nch);
                finished = 1;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_finished"}, finished, 1);
        start = 1'b0;
        wt_valid = 1'b0;
        win_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int acc;
        bit saw_wr;
        vecs[0] = '{1, 2, 1, 1, 2, 2, 18, 27};
        vecs[1] = '{2, 1, 1, 2, 1, 5, 99, 0};
        vecs[2] = '{8, 1, 255, 255, 255, 255, 4681800, 0};
        vecs[3] = '{3, 2, 3, 4, 10, 20, 1710, 1809};

        repeat (3) @(negedge clk);
        #1 check("reset_state", {busy, done, wt_ready, win_ready, mac_control, out_valid}, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            for (int c = 0; c < 8; c++)
                for (int t = 0; t < TAPS; t++) begin
                    wts[c][t] = 8'(c == 0 ? vecs[i].wa : vecs[i].wb);
                    for (int p = 0; p < 16; p++) wins[c][p][t] = 8'((c == 0 ? vecs[i].da : vecs[i].db) + p);
                end
            exp_v[0] = 24'(vecs[i].exp0);
            exp_v[1] = 24'(vecs[i].exp1);
            run_job(vecs[i].nch, vecs[i].npos, 0, 100, i == 0, i == 1, $sformatf("vec%0d", i), acc);
        end

        // Output stalled: only OFIFO_DEPTH windows may be accepted
        for (int c = 0; c < 8; c++)
            for (int t = 0; t < TAPS; t++) begin
                wts[c][t] = 8'd2;
                for (int p = 0; p < 16; p++) wins[c][p][t] = 8'(p + 1);
            end
        model(1, 8);
        run_job(1, 8, 20, 100, 0, 0, "stall", acc);
        check("stall_accepts", acc, 4);

        // Zero configuration: done next cycle, no weight request
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1;
            cfg_num_pos = k == 0 ? 5'd0 : 5'd3;
            cfg_num_ch = k == 0 ? 4'd2 : 4'd0;
            @(negedge clk);
            start = 1'b0;
            #1 check($sformatf("zero_cfg%0d_done", k), done, 1);
            saw_wr = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                #1 saw_wr |= wt_ready | busy;
            end
            check($sformatf("zero_cfg%0d_idle", k), saw_wr, 0);
        end

        // Abort mid-stream with results queued in the FIFO
        fill_random();
        @(negedge clk);
        start = 1'b1;
        cfg_num_pos = 5'd8;
        cfg_num_ch = 4'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wt_valid = 1'b1;
            wt_data = pack_w(0);
            win_valid = 1'b1;
            win_data = pack_d(0, i % 8);
            out_ready = 1'b0;
            @(negedge clk);
        end
        #1 check("pre_reset_fifo", out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wt_valid = 1'b0;
        win_valid = 1'b0;
        #1 check("abort_outputs", {busy, done, wt_ready, win_ready, mac_control, out_valid}, 0);
        model(2, 5);
        run_job(2, 5, 0, 70, 0, 0, "post_reset", acc);

        for (int j = 0; j < 6; j++) begin
            int nch = $urandom_range(1, 8), npos = $urandom_range(1, 16);
            fill_random();
            model(nch, npos);
            run_job(nch, npos, $urandom_range(0, 10), $urandom_range(30, 100), 0, 0, $sformatf("rand%0d", j), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pe_mac_scheduler.md
Name: pe_mac_scheduler

Overview:
- Sequences a TAPS-wide array of weight-stationary 8-bit multiplier units (control=1 loads weight, control=0 registers data*weight one cycle later) to compute patch-embedding convolution outputs.
- Outer loop is input channels, inner loop is output positions. Each channel's weight set is loaded once, then all windows for that channel are streamed.
- Per-position partial sums are kept in an internal buffer. Finished results leave through a small output FIFO with valid/ready backpressure.

Parameters:
- BIT_WIDTH, 8, activation/weight width
- ACC_WIDTH, 18, multiplier product width per tap
- TAPS, 9, MAC units in the array (kernel window size)
- OUT_WIDTH, 24, accumulated result width
- MAX_POS, 16, partial-sum buffer depth (max output positions)
- MAX_CH, 8, maximum input channels
- OFIFO_DEPTH, 4, output FIFO entries

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin job; ignored unless idle
- cfg_num_pos  in  clog2(MAX_POS+1)  positions per channel, latched on start
- cfg_num_ch  in  clog2(MAX_CH+1)  channels, latched on start
- busy  out  1  high from the start-accept cycle until done
- done  out  1  one-cycle pulse at job end
- wt_valid / wt_ready  in/out  1  weight-set handshake
- wt_data  in  TAPS*BIT_WIDTH  weight set for the current channel
- win_valid / win_ready  in/out  1  activation-window handshake
- win_data  in  TAPS*BIT_WIDTH  one window
- mac_control  out  1  to array; 1 = load weights
- mac_wt  out  TAPS*BIT_WIDTH  equals wt_data
- mac_data  out  TAPS*BIT_WIDTH  equals win_data
- mac_prod  in  TAPS*ACC_WIDTH  array products
- out_valid / out_ready  out/in  1  result handshake (FIFO head)
- out_data  out  OUT_WIDTH  result
- out_pos  out  clog2(MAX_POS)  position index of out_data

Behaviour:
- Reset: state IDLE; busy=0, done=0, wt_ready=0, win_ready=0, mac_control=0, out_valid=0; FIFO and pipeline valids cleared; counters zeroed. Reset mid-job aborts immediately; partial results are discarded.
- States are IDLE, LOAD_W, STREAM, DRAIN, FINISH.
- IDLE:
  - start with both cfg values nonzero: latch cfg, ch=0, pos=0, go to LOAD_W.
  - start with either cfg value zero: done pulses next cycle, no requests are issued, stay IDLE.
  - Values above MAX_POS/MAX_CH are unsupported.
- LOAD_W:
  - wt_ready=1 and mac_control=wt_valid.
  - On handshake the array captures the weights; go to STREAM.
- STREAM:
  - mac_control=0.
  - win_ready=1 iff pos<num_pos and backpressure permits.
  - On handshake (cycle t): pos increments. A stage-1 tag {pos, first=(ch==0), last=(ch==num_ch-1)} is registered.
  - Cycle t+1: sum of TAPS products (unsigned, zero-extended, modulo 2^OUT_WIDTH) is registered into stage 2 with its tag.
  - Cycle t+2: result = first ? sum : psum[pos]+sum (modulo 2^OUT_WIDTH).
    - If not last: write psum[pos].
    - If last: push {result, pos} into the FIFO.
  - When pos==num_pos after a handshake, go to DRAIN.
- Backpressure (last channel only): win_ready requires fifo_count + in-flight stage valids < OFIFO_DEPTH, so no result is ever dropped. Non-last channels are never throttled.
- DRAIN: wait until stage 1 and stage 2 are empty.
  - If not last channel: ch++, pos=0, go to LOAD_W.
  - If last channel: go to FINISH.
- FINISH: wait until the FIFO is empty and the final pop completes; pulse done for 1 cycle, busy=0, go to IDLE.
- FIFO behaviour:
  - out_valid = !empty; out_data/out_pos show the head.
  - Simultaneous push and pop when full is legal; pushes never exceed capacity.
  - FIFO order equals position order.
- Pipeline latency: window accepted at t → FIFO entry visible (out_valid) at t+3 when the FIFO is empty.
- wt_valid outside LOAD_W and win_valid outside STREAM are ignored; their data is don't-care.

Test Plan:
- num_ch=1, num_pos=2, weights all 1, windows all 2 and all 3, out_ready=1 → outputs 18 (pos0) then 27 (pos1). Each out_valid appears 3 cycles after its window handshake; done follows the last pop.
- num_ch=2, num_pos=1, ch0 weights all 1 / window all 1, ch1 weights all 2 / window all 5 → single output 9+90=99; wt_ready asserted twice.
- All weights and data 255, TAPS=9, num_ch=8, num_pos=1 → out_data = 8*9*65025 mod 2^24 = 4681800.
- num_ch=1, num_pos=8, out_ready=0 → win_ready deasserts after 4 accepts; releasing out_ready yields pos 0..7 in order, none lost.
- Reset asserted in STREAM with 2 results in the FIFO → next cycle all outputs at reset values; a new start runs cleanly from ch=0.
- start with cfg_num_pos=0 → done pulses next cycle, wt_ready never asserts; start while busy is ignored.
